// File: rtl/cpu_memory.sv
// Memory-side responder for the 8-bit CPU: 256-byte RAM with a byte-stream program loader.
// Optional write protection of addresses >= PROT_BASE is enabled by defining WRITE_PROTECT_EN.
module cpu_memory #(
  parameter int                DATA_W    = 8,
  parameter int                ADDR_W    = 8,
  parameter int                LOAD_LEN  = 256,
  parameter logic [ADDR_W-1:0] PROT_BASE = 8'hC0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              cpu_write,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_reset_n,
  input  logic              load_start,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_valid,
  output logic              load_ready,
  output logic              loading,
`ifdef WRITE_PROTECT_EN
  output logic              prot_fault,
`endif
  output logic              load_done
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_e;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(LOAD_LEN - 1);
`ifdef WRITE_PROTECT_EN
  localparam bit WP_EN = 1'b1;
`else
  localparam bit WP_EN = 1'b0;
`endif

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              load_done_q, load_done_d;
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] mem [2**ADDR_W];

  logic load_we, prot_drop, cpu_we;

  // Loader and CPU writes are mutually exclusive by state, so one RAM write port suffices.
  assign load_we   = (state_q == LOAD) && load_valid;
  assign prot_drop = WP_EN && (state_q == RUN) && cpu_write && (cpu_addr >= PROT_BASE);
  assign cpu_we    = (state_q == RUN) && cpu_write && !prot_drop;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    state_d     = state_q;
    cnt_d       = cnt_q;
    load_done_d = 1'b0;
    unique case (state_q)
      IDLE: if (load_start) begin
        state_d = LOAD;
        cnt_d   = '0;
      end
      LOAD: if (load_valid) begin
        if (cnt_q == LAST_IDX) begin
          state_d     = RUN;
          cnt_d       = '0;
          load_done_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RUN: if (load_start) begin
        state_d = LOAD;
        cnt_d   = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      state_q     <= IDLE;
      cnt_q       <= '0;
      load_done_q <= 1'b0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      load_done_q <= load_done_d;
      rdata_q     <= cpu_we ? cpu_wdata : mem[cpu_addr];
    end
  end

  // NOTE: the RAM array has no reset; its contents deliberately survive a reset.
  always_ff @(posedge clk) begin
    if (load_we)     mem[cnt_q]    <= load_data;
    else if (cpu_we) mem[cpu_addr] <= cpu_wdata;
  end

`ifdef WRITE_PROTECT_EN
  logic fault_q;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)          fault_q <= 1'b0;
    else if (load_start) fault_q <= 1'b0;
    else if (prot_drop)  fault_q <= 1'b1;
  end
  assign prot_fault = fault_q;
`endif

  assign cpu_rdata   = rdata_q;
  assign cpu_reset_n = (state_q == RUN);
  assign load_ready  = (state_q == LOAD);
  assign loading     = (state_q == LOAD);
  assign load_done   = load_done_q;

endmodule

// File: tb/tb_cpu_memory.sv
// Directed self-checking bench for cpu_memory with LOAD_LEN=4.
// Protection checks are compiled in only when WRITE_PROTECT_EN is defined.
module tb_cpu_memory;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] cpu_addr, cpu_wdata, cpu_rdata, load_data;
  logic       cpu_write, cpu_reset_n, load_start, load_valid;
  logic       load_ready, loading, load_done;
`ifdef WRITE_PROTECT_EN
  logic       prot_fault;
`endif

  int checks   = 0;
  int failures = 0;

  cpu_memory #(.DATA_W(8), .ADDR_W(8), .LOAD_LEN(4), .PROT_BASE(8'hC0)) dut (
    .clk        (clk),
    .reset      (reset),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_write  (cpu_write),
    .cpu_rdata  (cpu_rdata),
    .cpu_reset_n(cpu_reset_n),
    .load_start (load_start),
    .load_data  (load_data),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .loading    (loading),
`ifdef WRITE_PROTECT_EN
    .prot_fault (prot_fault),
`endif
    .load_done  (load_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic read_chk(input string tag, input logic [7:0] addr, input logic [7:0] exp);
    cpu_addr  = addr;
    cpu_write = 1'b0;
    tick();
    check(tag, cpu_rdata, exp);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] img1 [4];
    logic [7:0] img2 [4];
    img1 = '{8'h11, 8'h22, 8'h33, 8'h44};
    img2 = '{8'h41, 8'h42, 8'h43, 8'h44};

    reset = 1'b0; cpu_addr = '0; cpu_wdata = '0; cpu_write = 1'b0;
    load_start = 1'b0; load_data = '0; load_valid = 1'b0;
    tick(); tick();
    check("rst_cpu_reset_n", cpu_reset_n, 0);
    check("rst_load_ready",  load_ready,  0);
    check("rst_loading",     loading,     0);
    check("rst_load_done",   load_done,   0);
    check("rst_rdata",       cpu_rdata,   0);
    reset = 1'b1;
    tick();

    // First load; a CPU write and a second load_start arrive mid-load.
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    check("load_loading", loading, 1);
    check("load_cpu_rst", cpu_reset_n, 0);
    for (int i = 0; i < 4; i++) begin
      load_valid = 1'b1;
      load_data  = img1[i];
      if (i == 1) begin
        load_start = 1'b1;
        cpu_write  = 1'b1;
        cpu_addr   = 8'h00;
        cpu_wdata  = 8'hFF;
      end
      check($sformatf("load_ready_%0d", i), load_ready, 1);
      check($sformatf("load_done_low_%0d", i), load_done, 0);
      tick();
      if (i == 1) check("load_cpu_write_dropped_rdata", cpu_rdata, 8'h11);
      load_start = 1'b0;
      cpu_write  = 1'b0;
    end
    load_valid = 1'b0;
    check("done_pulse",       load_done,   1);
    check("done_cpu_reset_n", cpu_reset_n, 1);
    check("done_ready_low",   load_ready,  0);
    check("done_loading_low", loading,     0);
    tick();
    check("done_one_cycle", load_done, 0);

    for (int i = 0; i < 4; i++) read_chk($sformatf("read_img1_%0d", i), 8'(i), img1[i]);

    cpu_addr = 8'd10; cpu_wdata = 8'h5A; cpu_write = 1'b1;
    tick();
    check("wr10_wfirst", cpu_rdata, 8'h5A);
    read_chk("rd10", 8'd10, 8'h5A);
    cpu_addr = 8'd20; cpu_wdata = 8'hA5; cpu_write = 1'b1;
    tick();
    check("wr20_wfirst", cpu_rdata, 8'hA5);
    read_chk("rd20", 8'd20, 8'hA5);

    // Reload from RUN with a simultaneous byte (not accepted), gapped stream, then reset.
    load_start = 1'b1; load_valid = 1'b1; load_data = 8'h99;
    tick();
    load_start = 1'b0;
    check("reload_loading", loading, 1);
    check("reload_cpu_rst", cpu_reset_n, 0);
    load_data = 8'hD1;
    tick();
    load_valid = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    check("gap_ready", load_ready, 1);
    load_valid = 1'b1; load_data = 8'hD2;
    tick();
    load_valid = 1'b0;
    reset = 1'b0;
    #1;
    check("midrst_cpu_reset_n", cpu_reset_n, 0);
    check("midrst_loading",     loading,     0);
    check("midrst_load_done",   load_done,   0);
    tick();
    reset = 1'b1;
    tick();
    check("idle_load_done", load_done, 0);

    cpu_addr = 8'd10; cpu_wdata = 8'hEE; cpu_write = 1'b1;
    tick();
    check("idle_write_dropped", cpu_rdata, 8'h5A);
    read_chk("retain_0", 8'd0, 8'hD1);
    read_chk("retain_1", 8'd1, 8'hD2);
    read_chk("retain_2", 8'd2, 8'h33);
    read_chk("retain_10", 8'd10, 8'h5A);

    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      load_valid = 1'b1;
      load_data  = img2[i];
      tick();
    end
    load_valid = 1'b0;
    check("done2_pulse", load_done, 1);
    check("done2_cpu_reset_n", cpu_reset_n, 1);
    for (int i = 0; i < 4; i++) read_chk($sformatf("read_img2_%0d", i), 8'(i), img2[i]);
    read_chk("wrap_ff_untouched_20", 8'd20, 8'hA5);

`ifdef WRITE_PROTECT_EN
    check("wp_fault_init", prot_fault, 0);
    cpu_addr = 8'hBF; cpu_wdata = 8'h66; cpu_write = 1'b1;
    tick();
    check("wp_below_base_written", cpu_rdata, 8'h66);
    check("wp_below_base_nofault", prot_fault, 0);
    cpu_addr = 8'hC5; cpu_wdata = 8'h77; cpu_write = 1'b1;
    tick();
    cpu_write = 1'b0;
    check("wp_fault_set", prot_fault, 1);
    check("wp_wfirst_old", (cpu_rdata == 8'h77), 0);
    tick();
    check("wp_c5_unchanged", (cpu_rdata == 8'h77), 0);
    check("wp_fault_sticky", prot_fault, 1);
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    check("wp_fault_cleared", prot_fault, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cpu_memory.md
Name: cpu_memory

Overview:
Memory-side responder for the 8-bit CPU's memory bus. It holds a 256-byte single-port RAM that serves CPU reads and writes on address/data/write. A built-in program loader fills the RAM from a byte stream while holding the CPU in reset, then releases the CPU to run. It sits between the system loader (UART or bench) and the CPU top level.

Parameters:
DATA_W, 8, data bus width in bits
ADDR_W, 8, address width; RAM depth is 2**ADDR_W
LOAD_LEN, 256, bytes loaded per load sequence (1..2**ADDR_W)
PROT_BASE, 8'hC0, first write-protected address (used only with the optional feature)

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-low reset
cpu_addr  in  ADDR_W  CPU address bus
cpu_wdata  in  DATA_W  CPU write data
cpu_write  in  1  CPU write strobe, one write per cycle while high
cpu_rdata  out  DATA_W  registered read data to CPU
cpu_reset_n  out  1  active-low reset to CPU; low while not in RUN
load_start  in  1  pulse; begins a load sequence
load_data  in  DATA_W  loader byte
load_valid  in  1  loader byte valid
load_ready  out  1  block accepts a loader byte this cycle
loading  out  1  high while in LOAD
load_done  out  1  one-cycle pulse when the last byte is written
prot_fault  out  1  sticky write-protect violation (present only with WRITE_PROTECT_EN)

Behaviour:
- Reset values: cpu_rdata=0, cpu_reset_n=0, load_ready=0, loading=0, load_done=0, prot_fault=0, load counter=0, state=IDLE. RAM contents are not reset and are retained across reset.
- States:
  - IDLE: CPU held in reset. load_start -> LOAD.
  - LOAD: load_ready=1, loading=1, cpu_reset_n=0.
  - RUN: cpu_reset_n=1. load_start -> LOAD, which clears the counter and drops cpu_reset_n on the next edge.
- Loading:
  - A byte is accepted when load_valid && load_ready. It is written to mem[cnt] and cnt increments.
  - When the accepted byte has cnt==LOAD_LEN-1, the next cycle is RUN: load_ready=0, loading=0, cpu_reset_n=1, load_done=1 for exactly that cycle. The counter then resets to 0.
  - load_valid with load_ready=0 is ignored, and no byte is consumed.
  - load_start while in LOAD is ignored; the counter is not restarted.
  - load_start and load_valid in the same cycle from RUN or IDLE: only the transition happens, and the byte is not accepted.
- CPU reads:
  - cpu_rdata <= mem[cpu_addr] at every rising edge in all states, giving 1-cycle latency.
  - Read-during-write to the same address is write-first: cpu_rdata shows cpu_wdata.
- CPU writes:
  - Applied only in RUN.
  - Writes in IDLE and LOAD are dropped and do not affect cpu_rdata.
- Address wrap: cpu_addr covers the full depth. The load counter never exceeds LOAD_LEN-1.
- Reset mid-load: returns to IDLE with counter 0. Bytes already written stay in RAM. load_done is not pulsed.

Optional Feature:
Macro WRITE_PROTECT_EN.
- Defined:
  - CPU writes in RUN with cpu_addr >= PROT_BASE are dropped.
  - prot_fault sets the cycle after the dropped write and stays high until reset or the next load_start.
  - The loader may write any address.
  - A write-first read of a dropped write returns the old RAM data.
- Undefined: there is no prot_fault port, and all RUN writes are applied.

Test Plan:
- Reset, then load_start, then stream LOAD_LEN=4 bytes 11,22,33,44 with continuous valid -> load_ready high for 4 cycles; load_done pulses once on the cycle after byte 44; cpu_reset_n rises on that same cycle.
- After the load, CPU reads addr 0..3 -> cpu_rdata is 11,22,33,44, each one cycle after its address.
- In RUN, write 5A to addr 10, then read addr 10 -> 5A. A same-cycle read/write at addr 20 with data A5 returns A5 (write-first).
- Gap the load stream (valid low for 3 cycles mid-load), then assert reset after 2 bytes -> state IDLE, cpu_reset_n=0, no load_done. A new load of 4 bytes starts at addr 0.
- In LOAD, the CPU writes FF to addr 0 -> dropped; addr 0 holds the loaded byte after RUN. load_start during LOAD -> ignored.
- With WRITE_PROTECT_EN and PROT_BASE=C0: a CPU write of 77 to C5 -> dropped, prot_fault=1 next cycle, read C5 returns the old value. load_start clears prot_fault.
